iq_decim: RTL and testbench

Integrate-and-dump decimator for the receive baseband path. It sits directly downstream of the IQ demodulator and consumes its signed 5-bit I_BB/Q_BB samples. It averages each block of DECIM consecutive valid samples per channel, with rounding. Each averaged I/Q pair is presented to the chip-synchronisation stage on a valid/ready handshake, and an overrun flag is raised when the consumer falls behind.

---
 rtl/iq_decim.sv | 84 ++++++++
 tb/tb_iq_decim.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/iq_decim.sv
// Integrate-and-dump decimator: averages DECIM valid I/Q samples with round-half-up
// and presents each result on a registered valid/ready output with a sticky overrun flag.
module iq_decim #(
    parameter int IN_W  = 5,
    parameter int DECIM = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            in_valid,
    input  logic [IN_W-1:0] I_BB,
    input  logic [IN_W-1:0] Q_BB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IN_W-1:0] I_DEC,
    output logic [IN_W-1:0] Q_DEC,
    output logic            overrun
);
    localparam int LOG2  = $clog2(DECIM);
    localparam int ACC_W = IN_W + LOG2;
    localparam logic [LOG2-1:0] CNT_LAST = LOG2'(DECIM - 1);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(DECIM / 2);

    if (DECIM < 2 || DECIM > 16 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
        $error("iq_decim: DECIM must be a power of two in 2..16");
    end

    // Handshake: a result transfers on any edge where out_valid and out_ready are both 1.
    logic [LOG2-1:0]         cnt;
    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic signed [ACC_W-1:0] ext_i, ext_q;
    logic signed [ACC_W-1:0] sum_i, sum_q;
    logic signed [ACC_W-1:0] rnd_i, rnd_q;
    logic                    dump;
    logic                    unused_bits;

    assign ext_i = {{LOG2{I_BB[IN_W-1]}}, I_BB};
    assign ext_q = {{LOG2{Q_BB[IN_W-1]}}, Q_BB};
    assign sum_i = acc_i + ext_i;
    assign sum_q = acc_q + ext_q;
    assign rnd_i = sum_i + HALF;
    assign rnd_q = sum_q + HALF;
    assign dump  = in_valid && (cnt == CNT_LAST);

    // Dropping the low LOG2 bits of the rounded sum is the arithmetic right shift.
    assign unused_bits = ^{rnd_i[LOG2-1:0], rnd_q[LOG2-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            I_DEC     <= '0;
            Q_DEC     <= '0;
        end else if (clear) begin
            cnt       <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (dump) begin
                I_DEC     <= rnd_i[ACC_W-1:LOG2];
                Q_DEC     <= rnd_q[ACC_W-1:LOG2];
                out_valid <= 1'b1;
                acc_i     <= '0;
                acc_q     <= '0;
                cnt       <= '0;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (in_valid) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                cnt   <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_iq_decim.sv
// Directed bench for iq_decim: hand-computed averages, rounding, gaps, overrun,
// same-edge transfer/dump, and reset/clear in the middle of a block.
module tb_iq_decim;
    logic       clk;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic [4:0] I_BB;
    logic [4:0] Q_BB;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] I_DEC;
    logic [4:0] Q_DEC;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    iq_decim #(.IN_W(5), .DECIM(4)) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .in_valid(in_valid),
        .I_BB(I_BB),
        .Q_BB(Q_BB),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .I_DEC(I_DEC),
        .Q_DEC(Q_DEC),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [4:0] i, input logic [4:0] q);
        in_valid = 1'b1;
        I_BB     = i;
        Q_BB     = q;
        cyc();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic accept();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk_bit("accept_clears_valid", out_valid, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        I_BB      = '0;
        Q_BB      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_overrun", overrun, 1'b0);
        chk_val("rst_i_dec", I_DEC, 5'd0);
        chk_val("rst_q_dec", Q_DEC, 5'd0);

        // Basic average: I sum 13 -> 3, Q sum -64 -> -16
        feed(5'd3, -5'sd16);
        feed(5'd5, -5'sd16);
        feed(-5'sd2, -5'sd16);
        chk_bit("basic_not_yet", out_valid, 1'b0);
        feed(5'd7, -5'sd16);
        in_valid = 1'b0;
        chk_bit("basic_valid", out_valid, 1'b1);
        chk_val("basic_i", I_DEC, 5'd3);
        chk_val("basic_q", Q_DEC, -5'sd16);
        chk_bit("basic_overrun", overrun, 1'b0);
        idle();
        chk_bit("basic_holds_valid", out_valid, 1'b1);
        chk_val("basic_holds_i", I_DEC, 5'd3);
        accept();

        // Rounding: I sum 3 -> 1, Q sum -1 -> 0
        feed(5'd1, -5'sd1);
        feed(5'd1, 5'd0);
        feed(5'd1, 5'd0);
        feed(5'd0, 5'd0);
        chk_val("round_i_pos", I_DEC, 5'd1);
        chk_val("round_q_zero", Q_DEC, 5'd0);
        accept();

        // Rounding: I sum -5 -> -1, Q full-scale 15 -> 15
        feed(-5'sd1, 5'd15);
        feed(-5'sd1, 5'd15);
        feed(-5'sd1, 5'd15);
        feed(-5'sd2, 5'd15);
        chk_val("round_i_neg", I_DEC, -5'sd1);
        chk_val("round_q_max", Q_DEC, 5'd15);
        accept();

        // Gapped input: 4 valid samples over 9 cycles
        feed(5'd3, -5'sd16);
        idle();
        idle();
        feed(5'd5, -5'sd16);
        idle();
        feed(-5'sd2, -5'sd16);
        idle();
        idle();
        chk_bit("gap_not_yet", out_valid, 1'b0);
        feed(5'd7, -5'sd16);
        in_valid = 1'b0;
        chk_bit("gap_valid", out_valid, 1'b1);
        chk_val("gap_i", I_DEC, 5'd3);
        chk_val("gap_q", Q_DEC, -5'sd16);
        accept();

        // Backpressure: block1 I sum 10 -> 3; block2 I sum -16 -> -4, Q sum 20 -> 5
        feed(5'd1, 5'd0);
        feed(5'd2, 5'd0);
        feed(5'd3, 5'd0);
        feed(5'd4, 5'd0);
        chk_bit("bp_blk1_valid", out_valid, 1'b1);
        chk_val("bp_blk1_i", I_DEC, 5'd3);
        chk_bit("bp_blk1_no_overrun", overrun, 1'b0);
        repeat (4) feed(-5'sd4, 5'd5);
        in_valid = 1'b0;
        chk_bit("bp_valid", out_valid, 1'b1);
        chk_val("bp_i", I_DEC, -5'sd4);
        chk_val("bp_q", Q_DEC, 5'd5);
        chk_bit("bp_overrun", overrun, 1'b1);
        idle();
        chk_bit("bp_overrun_sticky", overrun, 1'b1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk_bit("clr_valid", out_valid, 1'b0);
        chk_bit("clr_overrun", overrun, 1'b0);
        chk_val("clr_holds_i", I_DEC, -5'sd4);

        // Same-edge transfer and dump: block1 I=2,Q=-3; block2 I=6,Q=0
        repeat (4) feed(5'd2, -5'sd3);
        chk_val("se_blk1_i", I_DEC, 5'd2);
        chk_val("se_blk1_q", Q_DEC, -5'sd3);
        repeat (3) feed(5'd6, 5'd0);
        out_ready = 1'b1;
        feed(5'd6, 5'd0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk_bit("se_valid", out_valid, 1'b1);
        chk_val("se_i", I_DEC, 5'd6);
        chk_val("se_q", Q_DEC, 5'd0);
        chk_bit("se_overrun", overrun, 1'b0);
        accept();

        // Asynchronous reset mid-block
        feed(5'd7, 5'd7);
        feed(5'd7, 5'd7);
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk_val("arst_i_dec", I_DEC, 5'd0);
        chk_val("arst_q_dec", Q_DEC, 5'd0);
        chk_bit("arst_valid", out_valid, 1'b0);
        #1;
        reset = 1'b0;
        cyc();
        // New block: I sum -32 -> -8, Q sum 4 -> 1
        feed(-5'sd8, 5'd1);
        feed(-5'sd8, 5'd1);
        feed(-5'sd8, 5'd1);
        chk_bit("arst_partial_lost", out_valid, 1'b0);
        feed(-5'sd8, 5'd1);
        in_valid = 1'b0;
        chk_bit("arst_blk_valid", out_valid, 1'b1);
        chk_val("arst_blk_i", I_DEC, -5'sd8);
        chk_val("arst_blk_q", Q_DEC, 5'd1);
        accept();

        // Clear mid-block; the sample on the clear edge is discarded
        feed(5'd7, 5'd7);
        feed(5'd7, 5'd7);
        clear = 1'b1;
        feed(5'd7, 5'd7);
        clear = 1'b0;
        chk_val("sclr_holds_i", I_DEC, -5'sd8);
        chk_bit("sclr_valid", out_valid, 1'b0);
        // New block: I sum 15 -> 4, Q sum -8 -> -2
        feed(5'd4, -5'sd2);
        feed(5'd4, -5'sd2);
        feed(5'd4, -5'sd2);
        chk_bit("sclr_partial_lost", out_valid, 1'b0);
        feed(5'd3, -5'sd2);
        in_valid = 1'b0;
        chk_bit("sclr_blk_valid", out_valid, 1'b1);
        chk_val("sclr_blk_i", I_DEC, 5'd4);
        chk_val("sclr_blk_q", Q_DEC, -5'sd2);
        chk_bit("sclr_blk_overrun", overrun, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
